// File: rtl/tmds_pkg.sv
// tmds_pkg: shared types, symbol tables and helper functions for the TMDS encoders.
//   mode_t       : per-beat symbol mode (CONTROL / VIDEO / TERC4 / GUARD)
//   CTRL_CODE    : 4 control-period symbols indexed by {c1,c0}
//   TERC4_CODE   : 16 data-island symbols indexed by the aux nibble
//   GUARD_*      : guard-band symbols
//   popcount8, qm_encode, video_use_xor : stage-1 video helpers
// Symbols are written MSB first: bit 9 is the leftmost digit.
package tmds_pkg;

    typedef enum logic [1:0] {
        MODE_CONTROL = 2'b00,
        MODE_VIDEO   = 2'b01,
        MODE_TERC4   = 2'b10,
        MODE_GUARD   = 2'b11
    } mode_t;

    localparam int unsigned SYM_W  = 10;
    localparam int unsigned BYTE_W = 8;

    localparam logic [SYM_W-1:0] CTRL_CODE [4] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    localparam logic [SYM_W-1:0] TERC4_CODE [16] = '{
        10'b1010011100,
        10'b1001100011,
        10'b1011100100,
        10'b1011100010,
        10'b0101110001,
        10'b0100011110,
        10'b0110001110,
        10'b0100111100,
        10'b1011001100,
        10'b0100111001,
        10'b0110011100,
        10'b1011000110,
        10'b1010001110,
        10'b1001110001,
        10'b0101100011,
        10'b1011000011
    };

    localparam logic [SYM_W-1:0] GUARD_VID_A = 10'b1011001100;
    localparam logic [SYM_W-1:0] GUARD_VID_B = 10'b0100110011;
    localparam logic [SYM_W-1:0] GUARD_DI    = 10'b0100110011;

    // Number of ones in a byte.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    // Transition-minimising choice: XOR chain when it yields fewer transitions.
    function automatic logic video_use_xor(input logic [7:0] d);
        logic [3:0] n;
        n = popcount8(d);
        return (n < 4'd4) || ((n == 4'd4) && d[0]);
    endfunction

    // Rolling XOR/XNOR chain; bit 8 records which one was used.
    function automatic logic [8:0] qm_encode(input logic [7:0] d, input logic use_xor);
        logic [8:0] q;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xor ? (q[i-1] ^ d[i]) : ~(q[i-1] ^ d[i]);
        end
        q[8] = use_xor;
        return q;
    endfunction

endpackage

// File: rtl/tmds_multi_encoder_if.sv
// tmds_multi_encoder_if: beat bus between the packet scheduler and the TMDS encoder.
//   master : scheduler side, drives valid_in/mode/guard_di/data/ctrl/aux,
//            observes valid_out/tmds/disparity
//   slave  : encoder side, the mirror image
// Channel c occupies data[8c+:8], ctrl[2c+:2], aux[4c+:4], tmds[10c+:10],
// disparity[DISP_W*c+:DISP_W].
interface tmds_multi_encoder_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DISP_W = 6
);
    import tmds_pkg::*;

    logic                       valid_in;
    mode_t                      mode;
    logic                       guard_di;
    logic [NUM_CH*8-1:0]        data;
    logic [NUM_CH*2-1:0]        ctrl;
    logic [NUM_CH*4-1:0]        aux;
    logic                       valid_out;
    logic [NUM_CH*10-1:0]       tmds;
    logic [NUM_CH*DISP_W-1:0]   disparity;

    modport master (
        output valid_in, mode, guard_di, data, ctrl, aux,
        input  valid_out, tmds, disparity
    );

    modport slave (
        input  valid_in, mode, guard_di, data, ctrl, aux,
        output valid_out, tmds, disparity
    );

endinterface

// File: rtl/tmds_channel_encoder.sv
// tmds_channel_encoder: one TMDS lane, 2-stage pipeline, owns its running disparity.
//   clk, rst    : pixel clock, async active-high reset
//   s2_en       : stage-2 beat qualifier (valid delayed by one cycle, from the top)
//   mode        : symbol mode of the beat entering stage 1
//   guard_di    : guard flavour (0 video, 1 data island)
//   data/ctrl/aux : per-lane video byte, control pair, TERC4 nibble
//   tmds        : registered 10-bit symbol
//   disparity   : registered signed running disparity
// CH_MOD3 selects which guard pattern this lane emits.
module tmds_channel_encoder
    import tmds_pkg::*;
#(
    parameter int unsigned DISP_W  = 6,
    parameter int unsigned CH_MOD3 = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s2_en,
    input  mode_t                    mode,
    input  logic                     guard_di,
    input  logic [7:0]               data,
    input  logic [1:0]               ctrl,
    input  logic [3:0]               aux,
    output logic [SYM_W-1:0]         tmds,
    output logic signed [DISP_W-1:0] disparity
);

    localparam logic signed [DISP_W-1:0] CNT_BYTE = DISP_W'(BYTE_W);
    localparam logic signed [DISP_W-1:0] CNT_TWO  = DISP_W'(2);

    // Stage 1 registers
    logic [8:0]  qm_q;
    logic [3:0]  qm_ones_q;
    mode_t       mode_q;
    logic        guard_di_q;
    logic [1:0]  ctrl_q;
    logic [3:0]  aux_q;
    logic [8:0]  qm_c;

    // Stage 2 registers
    logic [SYM_W-1:0]         tmds_q;
    logic signed [DISP_W-1:0] cnt_q;

    // Stage 2 next-state terms
    logic [SYM_W-1:0]         tmds_c;
    logic signed [DISP_W-1:0] cnt_c;
    logic signed [DISP_W-1:0] bal_c;
    logic                     cnt_zero_c;
    logic                     cnt_neg_c;
    logic                     cnt_pos_c;
    logic                     bal_zero_c;
    logic                     more_ones_c;
    logic                     more_zeros_c;

    // Transition-minimised word for this byte
    always_comb begin
        qm_c = qm_encode(data, video_use_xor(data));
    end

    // Stage 1: capture minimised word, its weight and the beat's side fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qm_q       <= '0;
            qm_ones_q  <= '0;
            mode_q     <= MODE_CONTROL;
            guard_di_q <= 1'b0;
            ctrl_q     <= '0;
            aux_q      <= '0;
        end else begin
            qm_q       <= qm_c;
            qm_ones_q  <= popcount8(qm_c[7:0]);
            mode_q     <= mode;
            guard_di_q <= guard_di;
            ctrl_q     <= ctrl;
            aux_q      <= aux;
        end
    end

    // Stage 2: symbol selection and disparity update; bubbles hold state
    always_comb begin
        tmds_c       = tmds_q;
        cnt_c        = cnt_q;
        // bal_c = N1 - N0 = 2*N1 - 8
        bal_c        = DISP_W'({qm_ones_q, 1'b0}) - CNT_BYTE;
        cnt_zero_c   = (cnt_q == '0);
        cnt_neg_c    = cnt_q[DISP_W-1];
        cnt_pos_c    = !cnt_neg_c && !cnt_zero_c;
        bal_zero_c   = (qm_ones_q == 4'd4);
        more_ones_c  = (qm_ones_q > 4'd4);
        more_zeros_c = (qm_ones_q < 4'd4);

        if (s2_en) begin
            case (mode_q)
                MODE_VIDEO: begin
                    if (cnt_zero_c || bal_zero_c) begin
                        tmds_c = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                        cnt_c  = qm_q[8] ? (cnt_q + bal_c) : (cnt_q - bal_c);
                    end else if ((cnt_pos_c && more_ones_c) || (cnt_neg_c && more_zeros_c)) begin
                        tmds_c = {1'b1, qm_q[8], ~qm_q[7:0]};
                        cnt_c  = cnt_q - bal_c + (qm_q[8] ? CNT_TWO : '0);
                    end else begin
                        tmds_c = {1'b0, qm_q[8], qm_q[7:0]};
                        cnt_c  = cnt_q + bal_c - (qm_q[8] ? '0 : CNT_TWO);
                    end
                end
                MODE_CONTROL: begin
                    tmds_c = CTRL_CODE[ctrl_q];
                    cnt_c  = '0;
                end
                MODE_TERC4: begin
                    tmds_c = TERC4_CODE[aux_q];
                    cnt_c  = '0;
                end
                MODE_GUARD: begin
                    if (!guard_di_q) begin
                        tmds_c = (CH_MOD3 == 1) ? GUARD_VID_B : GUARD_VID_A;
                    end else begin
                        // Lane 0 of a data-island guard still carries HSYNC/VSYNC via TERC4
                        tmds_c = (CH_MOD3 == 0) ? TERC4_CODE[aux_q] : GUARD_DI;
                    end
                    cnt_c = '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Stage 2 registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmds_q <= '0;
            cnt_q  <= '0;
        end else begin
            tmds_q <= tmds_c;
            cnt_q  <= cnt_c;
        end
    end

    assign tmds      = tmds_q;
    assign disparity = cnt_q;

endmodule

// File: rtl/tmds_multi_encoder.sv
// tmds_multi_encoder: NUM_CH-lane TMDS symbol encoder (video, control, TERC4, guard).
//   clk, rst : pixel clock, async active-high reset
//   bus      : slave side of tmds_multi_encoder_if carrying the input beat and the
//              encoded output beat (valid_out, tmds, disparity)
// Fixed two-cycle latency, one beat per cycle, no backpressure. Lanes share
// valid and mode but keep independent disparity.
module tmds_multi_encoder #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DISP_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    tmds_multi_encoder_if.slave  bus
);

    logic valid_s1_q;
    logic valid_s2_q;

    // Valid pipeline; stage-1 valid gates the stage-2 update in every lane
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_s1_q <= 1'b0;
            valid_s2_q <= 1'b0;
        end else begin
            valid_s1_q <= bus.valid_in;
            valid_s2_q <= valid_s1_q;
        end
    end

    assign bus.valid_out = valid_s2_q;

    // One encoder per lane
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        tmds_channel_encoder #(
            .DISP_W  (DISP_W),
            .CH_MOD3 (ch % 3)
        ) u_enc (
            .clk       (clk),
            .rst       (rst),
            .s2_en     (valid_s1_q),
            .mode      (bus.mode),
            .guard_di  (bus.guard_di),
            .data      (bus.data[8*ch +: 8]),
            .ctrl      (bus.ctrl[2*ch +: 2]),
            .aux       (bus.aux[4*ch +: 4]),
            .tmds      (bus.tmds[10*ch +: 10]),
            .disparity (bus.disparity[DISP_W*ch +: DISP_W])
        );
    end

endmodule

// File: tb/tb_tmds_multi_encoder.sv
// tb_tmds_multi_encoder: directed and streaming checks of tmds_multi_encoder.
module tb_tmds_multi_encoder;
    import tmds_pkg::*;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned DISP_W = 6;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tmds_multi_encoder_if #(.NUM_CH(NUM_CH), .DISP_W(DISP_W)) bus ();

    tmds_multi_encoder #(.NUM_CH(NUM_CH), .DISP_W(DISP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int model_cnt [NUM_CH];

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.valid_in = 1'b0;
        bus.mode     = MODE_CONTROL;
        bus.guard_di = 1'b0;
        bus.data     = '0;
        bus.ctrl     = '0;
        bus.aux      = '0;
    endtask

    task automatic reset_dut();
        set_idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < NUM_CH; c++) model_cnt[c] = 0;
    endtask

    function automatic logic [9:0] sym_of(input int c);
        return bus.tmds[10*c +: 10];
    endfunction

    function automatic int disp_of(input int c);
        logic signed [DISP_W-1:0] d;
        d = bus.disparity[DISP_W*c +: DISP_W];
        return int'(d);
    endfunction

    // DVI 1.0 reference encoder in plain integer arithmetic
    function automatic void dvi_enc(input logic [7:0] d, input int cnt_in,
                                    output logic [9:0] sym, output int cnt_out);
        int n1;
        int ones;
        int zeros;
        logic x;
        logic [8:0] q;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(d[i]);
        x = (n1 < 4) || ((n1 == 4) && d[0]);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = x ? (q[i-1] ^ d[i]) : ~(q[i-1] ^ d[i]);
        q[8] = x;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(q[i]);
        zeros = 8 - ones;
        if (cnt_in == 0 || ones == zeros) begin
            sym     = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            cnt_out = cnt_in + (q[8] ? (ones - zeros) : (zeros - ones));
        end else if ((cnt_in > 0 && ones > zeros) || (cnt_in < 0 && zeros > ones)) begin
            sym     = {1'b1, q[8], ~q[7:0]};
            cnt_out = cnt_in + 2 * int'(q[8]) + zeros - ones;
        end else begin
            sym     = {1'b0, q[8], q[7:0]};
            cnt_out = cnt_in + ones - zeros - 2 * int'(!q[8]);
        end
    endfunction

    // Receiver-side decode of a video symbol
    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] b;
        d = s[9] ? ~s[7:0] : s[7:0];
        b[0] = d[0];
        for (int i = 1; i < 8; i++) b[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return b;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.valid_in = 1'b1;
        bus.mode     = MODE_VIDEO;
        bus.data     = 24'hA5_3C_00;
        repeat (3) step();
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got %b want 0", bus.valid_out);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (sym_of(c) !== 10'd0) begin
                errors++;
                $display("FAIL rst_tmds ch%0d got %b want 0", c, sym_of(c));
            end
            checks++;
            if (disp_of(c) !== 0) begin
                errors++;
                $display("FAIL rst_disp ch%0d got %0d want 0", c, disp_of(c));
            end
        end
        rst = 1'b0;
        bus.valid_in = 1'b0;
        step();
        step();
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle_valid got %b want 0", bus.valid_out);
        end
        bus.valid_in = 1'b1;
        bus.data     = '0;
        step();
        bus.valid_in = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL first_beat_early got %b want 0", bus.valid_out);
        end
        step();
        checks++;
        if (bus.valid_out !== 1'b1 || sym_of(0) !== 10'b0100000000) begin
            errors++;
            $display("FAIL first_beat got v=%b sym=%b want v=1 sym=0100000000", bus.valid_out, sym_of(0));
        end
        step();
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL first_beat_single got %b want 0", bus.valid_out);
        end
    endtask

    task automatic test_video_zeros();
        reset_dut();
        bus.mode     = MODE_VIDEO;
        bus.data     = '0;
        bus.valid_in = 1'b1;
        step();
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL vz_lag got %b want 0", bus.valid_out);
        end
        step();
        bus.valid_in = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b1 || sym_of(0) !== 10'b0100000000 || disp_of(0) !== -8) begin
            errors++;
            $display("FAIL vz_beat0 got v=%b sym=%b cnt=%0d want v=1 sym=0100000000 cnt=-8",
                     bus.valid_out, sym_of(0), disp_of(0));
        end
        step();
        checks++;
        if (bus.valid_out !== 1'b1 || sym_of(0) !== 10'b1111111111 || disp_of(0) !== 2) begin
            errors++;
            $display("FAIL vz_beat1 got v=%b sym=%b cnt=%0d want v=1 sym=1111111111 cnt=2",
                     bus.valid_out, sym_of(0), disp_of(0));
        end
        step();
        checks++;
        if (bus.valid_out !== 1'b0 || sym_of(0) !== 10'b1111111111) begin
            errors++;
            $display("FAIL vz_hold got v=%b sym=%b want v=0 sym=1111111111", bus.valid_out, sym_of(0));
        end
    endtask

    // Back-to-back control beats, entered with nonzero disparity from the previous test
    task automatic test_control();
        logic [9:0] exp_sym [4];
        exp_sym[0] = 10'b1101010100;
        exp_sym[1] = 10'b0010101011;
        exp_sym[2] = 10'b0101010100;
        exp_sym[3] = 10'b1010101011;
        bus.mode = MODE_CONTROL;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                bus.valid_in = 1'b1;
                bus.ctrl     = {NUM_CH{2'(i)}};
            end else begin
                bus.valid_in = 1'b0;
            end
            step();
            if (i >= 1) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    checks++;
                    if (bus.valid_out !== 1'b1 || sym_of(c) !== exp_sym[i-1] || disp_of(c) !== 0) begin
                        errors++;
                        $display("FAIL ctrl ch%0d code%0d got v=%b sym=%b cnt=%0d want v=1 sym=%b cnt=0",
                                 c, i-1, bus.valid_out, sym_of(c), disp_of(c), exp_sym[i-1]);
                    end
                end
            end
        end
        step();
    endtask

    // Video beat (disparity leaves 0) then one TERC4 beat with distinct nibbles per lane
    task automatic test_terc4();
        logic [9:0] exp_sym [NUM_CH];
        exp_sym[0] = 10'b1010011100;
        exp_sym[1] = 10'b1010001110;
        exp_sym[2] = 10'b1011000011;
        bus.valid_in = 1'b1;
        bus.mode     = MODE_VIDEO;
        bus.data     = '0;
        step();
        bus.mode = MODE_TERC4;
        bus.aux  = {4'hF, 4'hC, 4'h0};
        step();
        bus.valid_in = 1'b0;
        step();
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (bus.valid_out !== 1'b1 || sym_of(c) !== exp_sym[c] || disp_of(c) !== 0) begin
                errors++;
                $display("FAIL terc4 ch%0d got v=%b sym=%b cnt=%0d want v=1 sym=%b cnt=0",
                         c, bus.valid_out, sym_of(c), disp_of(c), exp_sym[c]);
            end
        end
        step();
    endtask

    task automatic test_guard();
        logic [9:0] exp_sym [2][NUM_CH];
        exp_sym[0][0] = 10'b1011001100;
        exp_sym[0][1] = 10'b0100110011;
        exp_sym[0][2] = 10'b1011001100;
        exp_sym[1][0] = 10'b1010001110;
        exp_sym[1][1] = 10'b0100110011;
        exp_sym[1][2] = 10'b0100110011;
        bus.mode = MODE_GUARD;
        for (int i = 0; i <= 2; i++) begin
            if (i < 2) begin
                bus.valid_in = 1'b1;
                bus.guard_di = (i == 1);
                bus.aux      = (i == 1) ? {4'h0, 4'h0, 4'hC} : {4'h0, 4'h0, 4'h0};
            end else begin
                bus.valid_in = 1'b0;
            end
            step();
            if (i >= 1) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    checks++;
                    if (bus.valid_out !== 1'b1 || sym_of(c) !== exp_sym[i-1][c]) begin
                        errors++;
                        $display("FAIL guard di%0d ch%0d got v=%b sym=%b want v=1 sym=%b",
                                 i-1, c, bus.valid_out, sym_of(c), exp_sym[i-1][c]);
                    end
                end
            end
        end
        step();
    endtask

    // Control (zeroes disparity), A, bubble with junk data, B
    task automatic test_bubble();
        logic [7:0] a_byte [NUM_CH];
        logic [7:0] b_byte [NUM_CH];
        logic [9:0] exp_a [NUM_CH];
        logic [9:0] exp_b [NUM_CH];
        int         exp_cnt [NUM_CH];
        int         mid;
        a_byte[0] = 8'h00; a_byte[1] = 8'h5A; a_byte[2] = 8'hF1;
        b_byte[0] = 8'h00; b_byte[1] = 8'hC3; b_byte[2] = 8'h17;
        for (int c = 0; c < NUM_CH; c++) begin
            dvi_enc(a_byte[c], 0, exp_a[c], mid);
            dvi_enc(b_byte[c], mid, exp_b[c], exp_cnt[c]);
        end
        bus.valid_in = 1'b1;
        bus.mode     = MODE_CONTROL;
        bus.ctrl     = '0;
        step();
        bus.mode = MODE_VIDEO;
        for (int c = 0; c < NUM_CH; c++) bus.data[8*c +: 8] = a_byte[c];
        step();
        bus.valid_in = 1'b0;
        bus.data     = {NUM_CH{8'hFF}};
        step();
        bus.valid_in = 1'b1;
        for (int c = 0; c < NUM_CH; c++) bus.data[8*c +: 8] = b_byte[c];
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (bus.valid_out !== 1'b1 || sym_of(c) !== exp_a[c]) begin
                errors++;
                $display("FAIL bubble_a ch%0d got v=%b sym=%b want v=1 sym=%b", c, bus.valid_out, sym_of(c), exp_a[c]);
            end
        end
        step();
        bus.valid_in = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (bus.valid_out !== 1'b0 || sym_of(c) !== exp_a[c]) begin
                errors++;
                $display("FAIL bubble_hold ch%0d got v=%b sym=%b want v=0 sym=%b", c, bus.valid_out, sym_of(c), exp_a[c]);
            end
        end
        step();
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (bus.valid_out !== 1'b1 || sym_of(c) !== exp_b[c] || disp_of(c) !== exp_cnt[c]) begin
                errors++;
                $display("FAIL bubble_b ch%0d got v=%b sym=%b cnt=%0d want v=1 sym=%b cnt=%0d",
                         c, bus.valid_out, sym_of(c), disp_of(c), exp_b[c], exp_cnt[c]);
            end
        end
        step();
    endtask

    // Continuous random video beats on all lanes, checked against the reference model
    task automatic run_stream(input int n);
        logic [7:0] prev [NUM_CH];
        logic [7:0] cur [NUM_CH];
        logic [9:0] exp_sym;
        int         nxt;
        bus.mode = MODE_VIDEO;
        for (int c = 0; c < NUM_CH; c++) begin
            prev[c] = '0;
            cur[c]  = '0;
        end
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    cur[c] = 8'($urandom);
                    bus.data[8*c +: 8] = cur[c];
                end
                bus.valid_in = 1'b1;
            end else begin
                bus.valid_in = 1'b0;
            end
            step();
            if (i >= 1) begin
                checks++;
                if (bus.valid_out !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_valid beat%0d got %b want 1", i-1, bus.valid_out);
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    dvi_enc(prev[c], model_cnt[c], exp_sym, nxt);
                    model_cnt[c] = nxt;
                    checks++;
                    if (sym_of(c) !== exp_sym) begin
                        errors++;
                        $display("FAIL stream_sym beat%0d ch%0d got %b want %b", i-1, c, sym_of(c), exp_sym);
                    end
                    checks++;
                    if (tmds_decode(sym_of(c)) !== prev[c]) begin
                        errors++;
                        $display("FAIL stream_decode beat%0d ch%0d got %h want %h", i-1, c, tmds_decode(sym_of(c)), prev[c]);
                    end
                    checks++;
                    if (disp_of(c) !== nxt) begin
                        errors++;
                        $display("FAIL stream_cnt beat%0d ch%0d got %0d want %0d", i-1, c, disp_of(c), nxt);
                    end
                    checks++;
                    if (disp_of(c) > 10 || disp_of(c) < -10) begin
                        errors++;
                        $display("FAIL stream_bound beat%0d ch%0d got %0d want |cnt|<=10", i-1, c, disp_of(c));
                    end
                end
            end
            prev = cur;
        end
    endtask

    task automatic test_random_video();
        reset_dut();
        run_stream(1700);
        // Two beats in flight, then an asynchronous reset mid-cycle
        bus.valid_in = 1'b1;
        bus.data     = {NUM_CH{8'h00}};
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid got %b want 0", bus.valid_out);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (sym_of(c) !== 10'd0 || disp_of(c) !== 0) begin
                errors++;
                $display("FAIL midrst_clear ch%0d got sym=%b cnt=%0d want 0/0", c, sym_of(c), disp_of(c));
            end
        end
        bus.valid_in = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (bus.valid_out !== 1'b0 || sym_of(0) !== 10'd0) begin
            errors++;
            $display("FAIL midrst_discard got v=%b sym=%b want v=0 sym=0", bus.valid_out, sym_of(0));
        end
        for (int c = 0; c < NUM_CH; c++) model_cnt[c] = 0;
        run_stream(1700);
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        for (int c = 0; c < NUM_CH; c++) model_cnt[c] = 0;
        test_reset();
        test_video_zeros();
        test_control();
        test_terc4();
        test_guard();
        test_bubble();
        test_random_video();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
